// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: round-robin front end that time-shares one FIR MAC
// engine among NUM_CHANNELS sample streams, tags each job with its channel,
// returns the tagged result downstream and abandons jobs the engine never finishes.
module fir_channel_scheduler #(
    parameter int DATA_WIDTH     = 24,
    parameter int NUM_CHANNELS   = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int CHAN_WIDTH    = $clog2(NUM_CHANNELS)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] iv_din,
    input  logic [NUM_CHANNELS-1:0]            iv_din_valid,
    output logic [NUM_CHANNELS-1:0]            ov_din_ready,
    output logic [DATA_WIDTH-1:0]              ov_fir_din,
    output logic [CHAN_WIDTH-1:0]              ov_fir_chan,
    output logic                               o_fir_din_valid,
    input  logic                               i_fir_ready,
    input  logic [DATA_WIDTH-1:0]              iv_fir_dout,
    input  logic                               i_fir_dout_valid,
    output logic                               o_fir_ready,
    output logic [DATA_WIDTH-1:0]              ov_dout,
    output logic [CHAN_WIDTH-1:0]              ov_dout_chan,
    output logic                               o_dout_valid,
    input  logic                               i_dout_ready,
    output logic                               o_busy,
    output logic                               o_timeout,
    output logic [CHAN_WIDTH-1:0]              ov_timeout_chan
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CHAN_WIDTH-1:0] CHAN_LAST = CHAN_WIDTH'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESULT,
        S_OUTPUT,
        S_RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [CHAN_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]    tcount_q, tcount_d;
    logic [DATA_WIDTH-1:0]   fir_din_q, fir_din_d;
    logic [CHAN_WIDTH-1:0]   fir_chan_q, fir_chan_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [CHAN_WIDTH-1:0]   dout_chan_q, dout_chan_d;
    logic [CHAN_WIDTH-1:0]   timeout_chan_q, timeout_chan_d;
    logic                    timeout_q, timeout_d;
    logic                    fir_ready_q, fir_ready_d;

    logic                    grant_valid;
    logic [CHAN_WIDTH-1:0]   grant_idx;
    logic [DATA_WIDTH-1:0]   grant_sample;
    logic                    cand_hit;
    int                      cand;

    // Find the first valid channel at or after the pointer, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_hit    = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CHANNELS) begin
                cand = cand - NUM_CHANNELS;
            end
            cand_hit = 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (c == cand) begin
                    cand_hit = iv_din_valid[c];
                end
            end
            if (!grant_valid && cand_hit) begin
                grant_valid = 1'b1;
                grant_idx   = CHAN_WIDTH'(cand);
            end
        end
    end

    // Select the granted channel's sample and drive its one-hot accept while idle.
    always_comb begin
        grant_sample = '0;
        ov_din_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_idx == CHAN_WIDTH'(c)) begin
                grant_sample = iv_din[c*DATA_WIDTH +: DATA_WIDTH];
                if ((state_q == S_IDLE) && grant_valid && !i_rst) begin
                    ov_din_ready[c] = 1'b1;
                end
            end
        end
    end

    // Next-state logic: job sequencing, result capture and the abandon path.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        tcount_d       = tcount_q;
        fir_din_d      = fir_din_q;
        fir_chan_d     = fir_chan_q;
        dout_d         = dout_q;
        dout_chan_d    = dout_chan_q;
        timeout_chan_d = timeout_chan_q;
        timeout_d      = 1'b0;
        fir_ready_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    fir_din_d  = grant_sample;
                    fir_chan_d = grant_idx;
                    ptr_d      = (grant_idx == CHAN_LAST) ? '0 : grant_idx + CHAN_WIDTH'(1);
                    tcount_d   = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT_RESULT: begin
                tcount_d = tcount_q + CNT_WIDTH'(1);
                if ((state_q == S_ISSUE) && i_fir_ready) begin
                    state_d = S_WAIT_RESULT;
                end else if ((state_q == S_WAIT_RESULT) && i_fir_dout_valid) begin
                    dout_d      = iv_fir_dout;
                    dout_chan_d = fir_chan_q;
                    state_d     = S_OUTPUT;
                end else if (tcount_q == CNT_LAST) begin
                    timeout_d      = 1'b1;
                    fir_ready_d    = 1'b1;
                    timeout_chan_d = fir_chan_q;
                    tcount_d       = '0;
                    state_d        = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (i_dout_ready) begin
                    fir_ready_d = 1'b1;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset to an all-zero idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            tcount_q       <= '0;
            fir_din_q      <= '0;
            fir_chan_q     <= '0;
            dout_q         <= '0;
            dout_chan_q    <= '0;
            timeout_chan_q <= '0;
            timeout_q      <= 1'b0;
            fir_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            tcount_q       <= tcount_d;
            fir_din_q      <= fir_din_d;
            fir_chan_q     <= fir_chan_d;
            dout_q         <= dout_d;
            dout_chan_q    <= dout_chan_d;
            timeout_chan_q <= timeout_chan_d;
            timeout_q      <= timeout_d;
            fir_ready_q    <= fir_ready_d;
        end
    end

    assign ov_fir_din      = fir_din_q;
    assign ov_fir_chan     = fir_chan_q;
    assign o_fir_din_valid = (state_q == S_ISSUE);
    assign o_fir_ready     = fir_ready_q;
    assign ov_dout         = dout_q;
    assign ov_dout_chan    = dout_chan_q;
    assign o_dout_valid    = (state_q == S_OUTPUT);
    assign o_busy          = (state_q != S_IDLE);
    assign o_timeout       = timeout_q;
    assign ov_timeout_chan = timeout_chan_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb_fir_channel_scheduler: directed vectors and hand-written job sequences
// for the round-robin FIR channel scheduler (4 channels, 16-cycle timeout).
module tb_fir_channel_scheduler;

    localparam int DW = 24;
    localparam int NC = 4;
    localparam int TO = 16;
    localparam int CW = 2;
    localparam logic [DW-1:0] S = 24'h000123;
    localparam logic [DW-1:0] R = 24'h0A0B0C;

    logic               i_clk;
    logic               i_rst;
    logic [NC*DW-1:0]   iv_din;
    logic [NC-1:0]      iv_din_valid;
    logic [NC-1:0]      ov_din_ready;
    logic [DW-1:0]      ov_fir_din;
    logic [CW-1:0]      ov_fir_chan;
    logic               o_fir_din_valid;
    logic               i_fir_ready;
    logic [DW-1:0]      iv_fir_dout;
    logic               i_fir_dout_valid;
    logic               o_fir_ready;
    logic [DW-1:0]      ov_dout;
    logic [CW-1:0]      ov_dout_chan;
    logic               o_dout_valid;
    logic               i_dout_ready;
    logic               o_busy;
    logic               o_timeout;
    logic [CW-1:0]      ov_timeout_chan;

    logic [DW-1:0]      samp [NC];
    int                 checks = 0;
    int                 errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        fir_ready;
        logic        fir_dv;
        logic        dout_ready;
        logic [3:0]  e_din_ready;
        logic        e_fir_din_valid;
        logic        e_dout_valid;
        logic        e_fir_ready;
        logic        e_busy;
        logic [1:0]  e_fir_chan;
        logic [23:0] e_fir_din;
        logic [23:0] e_dout;
        logic [1:0]  e_dout_chan;
    } vec_t;

    vec_t vecs[$];

    fir_channel_scheduler #(
        .DATA_WIDTH     (DW),
        .NUM_CHANNELS   (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .iv_din           (iv_din),
        .iv_din_valid     (iv_din_valid),
        .ov_din_ready     (ov_din_ready),
        .ov_fir_din       (ov_fir_din),
        .ov_fir_chan      (ov_fir_chan),
        .o_fir_din_valid  (o_fir_din_valid),
        .i_fir_ready      (i_fir_ready),
        .iv_fir_dout      (iv_fir_dout),
        .i_fir_dout_valid (i_fir_dout_valid),
        .o_fir_ready      (o_fir_ready),
        .ov_dout          (ov_dout),
        .ov_dout_chan     (ov_dout_chan),
        .o_dout_valid     (o_dout_valid),
        .i_dout_ready     (i_dout_ready),
        .o_busy           (o_busy),
        .o_timeout        (o_timeout),
        .ov_timeout_chan  (ov_timeout_chan)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case a sequence wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyReset();
        i_rst            = 1'b1;
        iv_din_valid     = '0;
        i_fir_ready      = 1'b0;
        i_fir_dout_valid = 1'b0;
        i_dout_ready     = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        iv_din_valid     = v.valid;
        i_fir_ready      = v.fir_ready;
        i_fir_dout_valid = v.fir_dv;
        i_dout_ready     = v.dout_ready;
        #1;
    endtask

    task automatic checkRow(input int i, input vec_t v);
        checkOutput($sformatf("row%0d din_ready", i), 32'(ov_din_ready), 32'(v.e_din_ready));
        checkOutput($sformatf("row%0d fir_din_valid", i), 32'(o_fir_din_valid), 32'(v.e_fir_din_valid));
        checkOutput($sformatf("row%0d dout_valid", i), 32'(o_dout_valid), 32'(v.e_dout_valid));
        checkOutput($sformatf("row%0d fir_ready", i), 32'(o_fir_ready), 32'(v.e_fir_ready));
        checkOutput($sformatf("row%0d busy", i), 32'(o_busy), 32'(v.e_busy));
        checkOutput($sformatf("row%0d fir_chan", i), 32'(ov_fir_chan), 32'(v.e_fir_chan));
        checkOutput($sformatf("row%0d fir_din", i), 32'(ov_fir_din), 32'(v.e_fir_din));
        checkOutput($sformatf("row%0d dout", i), 32'(ov_dout), 32'(v.e_dout));
        checkOutput($sformatf("row%0d dout_chan", i), 32'(ov_dout_chan), 32'(v.e_dout_chan));
        checkOutput($sformatf("row%0d timeout", i), 32'(o_timeout), 32'h0);
    endtask

    function automatic void addRow(input logic [3:0] valid, input logic fr, input logic dv,
                                   input logic dr, input logic [3:0] e_dr, input logic e_fdv,
                                   input logic e_dv, input logic e_fr, input logic e_busy,
                                   input logic [1:0] e_chan, input logic [23:0] e_fdin,
                                   input logic [23:0] e_dout, input logic [1:0] e_dchan);
        vec_t v;
        v.valid           = valid;
        v.fir_ready       = fr;
        v.fir_dv          = dv;
        v.dout_ready      = dr;
        v.e_din_ready     = e_dr;
        v.e_fir_din_valid = e_fdv;
        v.e_dout_valid    = e_dv;
        v.e_fir_ready     = e_fr;
        v.e_busy          = e_busy;
        v.e_fir_chan      = e_chan;
        v.e_fir_din       = e_fdin;
        v.e_dout          = e_dout;
        v.e_dout_chan     = e_dchan;
        vecs.push_back(v);
    endfunction

    // One complete job with an engine model: grant, issue, result, optional
    // downstream back-pressure, then the release pulse.
    task automatic serveJob(input int exp_chan, input int delay, input int hold, input logic [DW-1:0] result);
        int waited;
        waited = 0;
        while (ov_din_ready == '0 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput($sformatf("job ch%0d grant", exp_chan), 32'(ov_din_ready), 32'(1) << exp_chan);
        tick();
        checkOutput($sformatf("job ch%0d issue valid", exp_chan), 32'(o_fir_din_valid), 32'h1);
        checkOutput($sformatf("job ch%0d issue chan", exp_chan), 32'(ov_fir_chan), 32'(exp_chan));
        checkOutput($sformatf("job ch%0d issue sample", exp_chan), 32'(ov_fir_din), 32'(samp[exp_chan]));
        i_fir_ready = 1'b1;
        tick();
        i_fir_ready = 1'b0;
        repeat (delay) tick();
        iv_fir_dout      = result;
        i_fir_dout_valid = 1'b1;
        tick();
        i_fir_dout_valid = 1'b0;
        iv_fir_dout      = ~result;
        #1;
        checkOutput($sformatf("job ch%0d dout_valid", exp_chan), 32'(o_dout_valid), 32'h1);
        checkOutput($sformatf("job ch%0d dout", exp_chan), 32'(ov_dout), 32'(result));
        checkOutput($sformatf("job ch%0d dout_chan", exp_chan), 32'(ov_dout_chan), 32'(exp_chan));
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput($sformatf("hold%0d dout_valid", h), 32'(o_dout_valid), 32'h1);
            checkOutput($sformatf("hold%0d dout", h), 32'(ov_dout), 32'(result));
            checkOutput($sformatf("hold%0d din_ready", h), 32'(ov_din_ready), 32'h0);
            checkOutput($sformatf("hold%0d fir_ready", h), 32'(o_fir_ready), 32'h0);
        end
        i_dout_ready = 1'b1;
        tick();
        i_dout_ready = 1'b0;
        #1;
        checkOutput($sformatf("job ch%0d release", exp_chan), 32'(o_fir_ready), 32'h1);
        checkOutput($sformatf("job ch%0d dout dropped", exp_chan), 32'(o_dout_valid), 32'h0);
        tick();
        checkOutput($sformatf("job ch%0d release done", exp_chan), 32'(o_fir_ready), 32'h0);
        checkOutput($sformatf("job ch%0d idle", exp_chan), 32'(o_busy), 32'h0);
    endtask

    initial begin
        samp[0] = 24'h000ABC;
        samp[1] = 24'h000DEF;
        samp[2] = S;
        samp[3] = 24'h000456;
        iv_din           = {samp[3], samp[2], samp[1], samp[0]};
        i_rst            = 1'b1;
        iv_din_valid     = '0;
        i_fir_ready      = 1'b0;
        iv_fir_dout      = R;
        i_fir_dout_valid = 1'b0;
        i_dout_ready     = 1'b0;

        // Single job on channel 2 with a 10-cycle engine, cycle by cycle.
        addRow(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 24'h0, 2'd0);
        addRow(4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h0, 24'h0, 2'd0);
        addRow(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, S, 24'h0, 2'd0);
        addRow(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, S, 24'h0, 2'd0);
        for (int w = 0; w < 9; w++) begin
            addRow(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, S, 24'h0, 2'd0);
        end
        addRow(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, S, 24'h0, 2'd0);
        addRow(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, S, R, 2'd2);
        addRow(4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, S, R, 2'd2);
        addRow(4'h4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, S, R, 2'd2);
        addRow(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, S, R, 2'd2);

        applyReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkRow(i, vecs[i]);
            tick();
        end

        // All channels requesting: grants rotate 0,1,2,3,0,1,2,3; job 3 back-pressured.
        $display("[TB] round-robin sequence");
        applyReset();
        iv_din_valid = 4'hF;
        #1;
        for (int j = 0; j < 8; j++) begin
            serveJob(j % NC, 1 + j, (j == 3) ? 20 : 0, 24'hA00000 | 24'(j));
        end

        // Engine never answers for channel 1: abandon after 16 cycles.
        $display("[TB] timeout sequence");
        applyReset();
        iv_din_valid = 4'b0010;
        #1;
        checkOutput("to grant", 32'(ov_din_ready), 32'h2);
        tick();
        iv_din_valid = 4'b0000;
        checkOutput("to issue", 32'(o_fir_din_valid), 32'h1);
        for (int c = 1; c < TO; c++) begin
            tick();
            checkOutput($sformatf("to quiet c%0d", c), 32'(o_timeout), 32'h0);
        end
        checkOutput("to still busy", 32'(o_busy), 32'h1);
        tick();
        checkOutput("to pulse", 32'(o_timeout), 32'h1);
        checkOutput("to chan", 32'(ov_timeout_chan), 32'h1);
        checkOutput("to release", 32'(o_fir_ready), 32'h1);
        checkOutput("to idle", 32'(o_busy), 32'h0);
        tick();
        checkOutput("to pulse end", 32'(o_timeout), 32'h0);
        checkOutput("to release end", 32'(o_fir_ready), 32'h0);
        checkOutput("to chan held", 32'(ov_timeout_chan), 32'h1);
        iv_din_valid = 4'hF;
        #1;
        checkOutput("to next grant", 32'(ov_din_ready), 32'h4);

        // Reset while a result sits in OUTPUT; pointer must restart at 0.
        $display("[TB] reset during output");
        iv_din_valid = 4'b0010;
        #1;
        checkOutput("rst grant", 32'(ov_din_ready), 32'h2);
        tick();
        iv_din_valid = 4'b0000;
        i_fir_ready  = 1'b1;
        tick();
        i_fir_ready      = 1'b0;
        iv_fir_dout      = 24'h777777;
        i_fir_dout_valid = 1'b1;
        tick();
        i_fir_dout_valid = 1'b0;
        #1;
        checkOutput("rst in output", 32'(o_dout_valid), 32'h1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        checkOutput("rst din_ready", 32'(ov_din_ready), 32'h0);
        checkOutput("rst fir_din_valid", 32'(o_fir_din_valid), 32'h0);
        checkOutput("rst fir_ready", 32'(o_fir_ready), 32'h0);
        checkOutput("rst dout_valid", 32'(o_dout_valid), 32'h0);
        checkOutput("rst busy", 32'(o_busy), 32'h0);
        checkOutput("rst timeout", 32'(o_timeout), 32'h0);
        checkOutput("rst fir_din", 32'(ov_fir_din), 32'h0);
        checkOutput("rst fir_chan", 32'(ov_fir_chan), 32'h0);
        checkOutput("rst dout", 32'(ov_dout), 32'h0);
        checkOutput("rst dout_chan", 32'(ov_dout_chan), 32'h0);
        checkOutput("rst timeout_chan", 32'(ov_timeout_chan), 32'h0);
        iv_din_valid = 4'b1001;
        #1;
        checkOutput("rst pointer", 32'(ov_din_ready), 32'h1);

        // Result arrives on the very cycle the timeout would fire: result wins.
        $display("[TB] result on timeout cycle");
        applyReset();
        iv_din_valid = 4'b0010;
        #1;
        tick();
        iv_din_valid = 4'b0000;
        i_fir_ready  = 1'b1;
        tick();
        i_fir_ready = 1'b0;
        repeat (TO - 2) tick();
        checkOutput("race still waiting", 32'(o_busy), 32'h1);
        checkOutput("race no output yet", 32'(o_dout_valid), 32'h0);
        iv_fir_dout      = 24'h5A5A5A;
        i_fir_dout_valid = 1'b1;
        tick();
        i_fir_dout_valid = 1'b0;
        #1;
        checkOutput("race dout_valid", 32'(o_dout_valid), 32'h1);
        checkOutput("race dout", 32'(ov_dout), 32'h5A5A5A);
        checkOutput("race dout_chan", 32'(ov_dout_chan), 32'h1);
        checkOutput("race no timeout", 32'(o_timeout), 32'h0);
        checkOutput("race no early release", 32'(o_fir_ready), 32'h0);
        i_dout_ready = 1'b1;
        tick();
        i_dout_ready = 1'b0;
        #1;
        checkOutput("race release", 32'(o_fir_ready), 32'h1);
        checkOutput("race release no timeout", 32'(o_timeout), 32'h0);
        tick();
        checkOutput("race idle no timeout", 32'(o_timeout), 32'h0);
        checkOutput("race timeout_chan", 32'(ov_timeout_chan), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
- Round-robin scheduler that time-shares one FIR MAC engine among NUM_CHANNELS independent sample streams.
- Arbitrates the per-channel valid/ready inputs and issues one sample at a time to the engine, tagged with the channel index. The engine uses that index to select the matching history bank.
- Captures the engine's result pulse and presents it downstream with its channel tag, then releases the engine.
- Sits between the per-channel input stages and the FIR engine. It owns the engine's din_valid/ready and dout_valid/ready handshakes.

Parameters:
- DATA_WIDTH, 24, sample and result width in bits.
- NUM_CHANNELS, 4, number of requesting channels; must be ≥2.
- TIMEOUT_CYCLES, 256, maximum cycles from issue to engine result before the job is abandoned.
- CHAN_WIDTH (localparam), $clog2(NUM_CHANNELS), width of the channel tag.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- iv_din  in  NUM_CHANNELS*DATA_WIDTH  packed channel samples; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- iv_din_valid  in  NUM_CHANNELS  per-channel sample valid.
- ov_din_ready  out  NUM_CHANNELS  per-channel accept; one-hot or zero.
- ov_fir_din  out  DATA_WIDTH  sample to the engine.
- ov_fir_chan  out  CHAN_WIDTH  channel tag to the engine (history bank select).
- o_fir_din_valid  out  1  sample valid to the engine.
- i_fir_ready  in  1  engine pulse: sample consumed.
- iv_fir_dout  in  DATA_WIDTH  engine result.
- i_fir_dout_valid  in  1  engine one-cycle result-valid pulse.
- o_fir_ready  out  1  release pulse to the engine's i_ready.
- ov_dout  out  DATA_WIDTH  filtered result.
- ov_dout_chan  out  CHAN_WIDTH  channel tag of ov_dout.
- o_dout_valid  out  1  result valid; held until accepted.
- i_dout_ready  in  1  downstream accept.
- o_busy  out  1  high whenever the state is not IDLE.
- o_timeout  out  1  one-cycle pulse when a job is abandoned.
- ov_timeout_chan  out  CHAN_WIDTH  channel of the last abandoned job; holds its value.

Behaviour:
- Reset (i_rst=1 on a clock edge), from any state including mid-job:
  - State goes to IDLE; the round-robin pointer goes to 0 (channel 0 has first priority).
  - All outputs read 0: ov_din_ready, o_fir_din_valid, o_fir_ready, o_dout_valid, o_busy, o_timeout, ov_fir_din, ov_fir_chan, ov_dout, ov_dout_chan, ov_timeout_chan.
  - The timeout counter clears. No output pulse is emitted on or after the reset cycle.
- States: IDLE, ISSUE, WAIT_RESULT, OUTPUT, RELEASE.
- IDLE:
  - Grant is combinational: the first c with iv_din_valid[c]=1, searching from the pointer upward with wrap-around.
  - ov_din_ready[grant]=1 in that same cycle; the transfer completes on that edge.
  - On the edge: latch the sample into ov_fir_din and the grant into ov_fir_chan; set the pointer to (grant+1) mod NUM_CHANNELS; go to ISSUE.
  - With no valid input, stay in IDLE with ov_din_ready=0.
- ISSUE:
  - o_fir_din_valid=1; ov_fir_din and ov_fir_chan are held stable.
  - On i_fir_ready=1, go to WAIT_RESULT.
- WAIT_RESULT:
  - On i_fir_dout_valid=1, register iv_fir_dout into ov_dout and ov_fir_chan into ov_dout_chan; go to OUTPUT.
  - A dout_valid pulse arriving in any other state is ignored.
- OUTPUT:
  - o_dout_valid=1; ov_dout and ov_dout_chan are held until i_dout_ready=1.
  - On acceptance, go to RELEASE.
- RELEASE: o_fir_ready=1 for exactly one cycle, then go to IDLE. Earliest next grant is the following cycle.
- Job latency: minimum input-accept to o_dout_valid is 3 cycles plus the engine's processing time.
- Throughput: with an always-ready downstream, at most one job per (engine time + 4) cycles.
- Timeout:
  - The counter increments each cycle in ISSUE or WAIT_RESULT and clears on entry to ISSUE.
  - If it reaches TIMEOUT_CYCLES-1 without the exit event, the next cycle does all of the following:
    - o_timeout pulses for 1 cycle.
    - ov_timeout_chan is set to ov_fir_chan.
    - o_fir_ready pulses for 1 cycle, so the engine is not left parked.
    - The state goes to IDLE.
  - The sample is dropped. The pointer is unchanged, so fairness is still preserved.
- Simultaneous events:
  - If an exit event (i_fir_ready in ISSUE, or i_fir_dout_valid in WAIT_RESULT) lands on the timeout cycle, the exit event wins and no timeout pulse is emitted.
- Starvation bound: a continuously valid channel is granted within NUM_CHANNELS jobs.
- Invariants: ov_din_ready is never asserted outside IDLE and is never multi-hot.
- Arithmetic: none; data passes bit-exact.

Test Plan:
- Reset, then only channel 2 valid with sample 0x000123; engine model with a 10-cycle result of 0x0A0B0C → ov_din_ready=4'b0100 for 1 cycle; ov_fir_chan=2; ov_dout=0x0A0B0C with ov_dout_chan=2; one o_fir_ready pulse after i_dout_ready.
- All 4 channels valid continuously for 8 jobs → grant order 0,1,2,3,0,1,2,3; each channel's result is tagged correctly.
- Downstream holds i_dout_ready=0 for 20 cycles → o_dout_valid and ov_dout stay stable; no new ov_din_ready; o_fir_ready is held off until acceptance.
- Engine never returns a result (TIMEOUT_CYCLES=16), channel 1 → o_timeout pulses 16 cycles after ISSUE entry; ov_timeout_chan=1; o_fir_ready pulses; the next grant goes to channel 2.
- i_fir_dout_valid lands on the timeout cycle → the result is output normally; o_timeout=0.
- i_rst asserted during OUTPUT → the next cycle has all outputs 0 and state IDLE; the pointer restarts at channel 0.
